// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK command sequencer.
//  - OP_* : command opcodes; each opcode is the {J,K} pair it drives
//  - state_t : sequencer FSM states
//  - jk_next() : next Q of a JK flip-flop given J, K and the current Q
package jk_seq_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        logic q_n;
        case ({j, k})
            OP_HOLD:  q_n = q;
            OP_RESET: q_n = 1'b0;
            OP_SET:   q_n = 1'b1;
            default:  q_n = ~q;
        endcase
        return q_n;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with flush.
// Ports:
//  i_clk            clock
//  i_rst            synchronous reset, active low
//  i_push / i_data  write request and data (ignored when full)
//  i_pop            read request (ignored when empty)
//  i_flush          drop all entries; overrides push and pop
//  o_data           head entry (show-ahead, valid while !o_empty)
//  o_full/o_empty   registered status flags
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_full;
    logic          r_empty;
    logic [AW:0]   w_wr_next;
    logic [AW:0]   w_rd_next;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !r_full  && !i_flush;
    assign w_pop  = i_pop  && !r_empty && !i_flush;

    always_comb begin
        w_wr_next = r_wr_ptr + (AW+1)'(w_push);
        w_rd_next = r_rd_ptr + (AW+1)'(w_pop);
        if (i_flush) begin
            w_wr_next = '0;
            w_rd_next = '0;
        end
    end

    // Flags are registered from the next pointers, so they are true
    // registers yet always consistent with the pointers they describe.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            // Same index, different wrap bit -> full.
            r_full   <= (w_wr_next ^ w_rd_next) == {1'b1, {AW{1'b0}}};
            r_empty  <= (w_wr_next == w_rd_next);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Show-ahead read: the sequencer must issue the head entry on the very
    // edge it pops it.
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Upstream driver for a JK flip-flop. Queues HOLD/RESET/SET/TOGGLE commands,
// replays each onto registered J/K for (rpt+1) cycles, tracks a shadow Q and
// flags any divergence of the fed-back Q.
// Ports:
//  i_clk, i_rst (sync, active low)
//  i_cmd_valid/o_cmd_ready, i_cmd_op[1:0], i_cmd_rpt   command handshake
//  i_abort      flush queue and active command
//  i_clr_err    clear sticky mismatch
//  i_q_fb       Q fed back from the flip-flop
//  o_j_out/o_k_out/o_ff_rst   registered flip-flop drive
//  o_q_model    shadow Q
//  o_busy       command active or queue non-empty
//  o_mismatch   sticky Q divergence flag
//  o_done_cnt   completed commands, wrapping
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RPT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [RPT_W-1:0] i_cmd_rpt,
    input  logic             i_abort,
    input  logic             i_clr_err,
    input  logic             i_q_fb,
    output logic             o_j_out,
    output logic             o_k_out,
    output logic             o_ff_rst,
    output logic             o_q_model,
    output logic             o_busy,
    output logic             o_mismatch,
    output logic [CNT_W-1:0] o_done_cnt
);

    localparam int FW = 2 + RPT_W;

    state_t           r_state;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_j;
    logic             r_k;
    logic             r_ff_rst;
    logic             r_q_model;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_done_cnt;

    logic [FW-1:0]    w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_last;

    assign w_push = i_cmd_valid && !w_full && !i_abort;
    // r_rpt_cnt counts the cycles still to go after the current one.
    assign w_last = (r_state == ST_ISSUE) && (r_rpt_cnt == '0);
    assign w_pop  = !i_abort && !w_empty && ((r_state == ST_IDLE) || w_last);

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  ({i_cmd_op, i_cmd_rpt}),
        .i_pop   (w_pop),
        .i_flush (i_abort),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_rpt_cnt  <= '0;
            r_j        <= 1'b0;
            r_k        <= 1'b0;
            r_done_cnt <= '0;
        end else if (i_abort) begin
            // Abort drops the active command without counting it.
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
            r_j       <= 1'b0;
            r_k       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        {r_j, r_k} <= w_head[FW-1 -: 2];
                        r_rpt_cnt  <= w_head[RPT_W-1:0];
                        r_state    <= ST_ISSUE;
                    end
                end
                default: begin
                    if (r_rpt_cnt != '0) begin
                        r_rpt_cnt <= r_rpt_cnt - RPT_W'(1);
                    end else begin
                        r_done_cnt <= r_done_cnt + CNT_W'(1);
                        if (!w_empty) begin
                            // Back-to-back: next command starts with no bubble.
                            {r_j, r_k} <= w_head[FW-1 -: 2];
                            r_rpt_cnt  <= w_head[RPT_W-1:0];
                        end else begin
                            r_j     <= 1'b0;
                            r_k     <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Shadow flip-flop and comparator. The shadow follows the J/K actually
    // presented to the flip-flop, so abort does not disturb it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ff_rst   <= 1'b1;
            r_q_model  <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_ff_rst  <= 1'b0;
            r_q_model <= r_ff_rst ? 1'b0 : jk_next(r_j, r_k, r_q_model);
            if (i_clr_err) begin
                r_mismatch <= 1'b0;
            end else if (!r_ff_rst && (i_q_fb != r_q_model)) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign o_cmd_ready = !w_full;
    assign o_j_out     = r_j;
    assign o_k_out     = r_k;
    assign o_ff_rst    = r_ff_rst;
    assign o_q_model   = r_q_model;
    assign o_busy      = (r_state == ST_ISSUE) || !w_empty;
    assign o_mismatch  = r_mismatch;
    assign o_done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Testbench for jk_cmd_sequencer: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int RPT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [RPT_W-1:0] cmd_rpt;
    logic             abort;
    logic             clr_err;
    logic             q_fb;
    logic             j_out;
    logic             k_out;
    logic             ff_rst;
    logic             q_model;
    logic             busy;
    logic             mismatch;
    logic [CNT_W-1:0] done_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [5:0]       m_fifo [$];
    bit               m_active;
    int               m_left;
    logic             m_j, m_k, m_q, m_ffrst, m_mis, m_ready;
    logic [CNT_W-1:0] m_done;

    // q_fb drive controls
    bit               stuck_en  = 1'b0;
    logic             stuck_val = 1'b0;
    logic             flip_q    = 1'b0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(
        .DEPTH (DEPTH),
        .RPT_W (RPT_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_rpt   (cmd_rpt),
        .i_abort     (abort),
        .i_clr_err   (clr_err),
        .i_q_fb      (q_fb),
        .o_j_out     (j_out),
        .o_k_out     (k_out),
        .o_ff_rst    (ff_rst),
        .o_q_model   (q_model),
        .o_busy      (busy),
        .o_mismatch  (mismatch),
        .o_done_cnt  (done_cnt)
    );

    function automatic logic jk_ref(input logic j, input logic k, input logic q);
        if (j && k)  return ~q;
        if (j)       return 1'b1;
        if (k)       return 1'b0;
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        logic       nq;
        logic [5:0] c;
        bit         take;
        if (!rst) begin
            m_fifo.delete();
            m_active = 1'b0;
            m_left   = 0;
            m_j      = 1'b0;
            m_k      = 1'b0;
            m_ffrst  = 1'b1;
            m_q      = 1'b0;
            m_mis    = 1'b0;
            m_done   = '0;
            m_ready  = 1'b1;
            return;
        end
        nq = m_ffrst ? 1'b0 : jk_ref(m_j, m_k, m_q);
        if (clr_err)                       m_mis = 1'b0;
        else if (!m_ffrst && q_fb !== m_q) m_mis = 1'b1;
        if (abort) begin
            m_fifo.delete();
            m_active = 1'b0;
            m_j      = 1'b0;
            m_k      = 1'b0;
        end else begin
            take = !m_active;
            if (m_active) begin
                m_left--;
                if (m_left == 0) begin
                    m_done++;
                    m_active = 1'b0;
                    take     = 1'b1;
                end
            end
            if (take) begin
                if (m_fifo.size() > 0) begin
                    c          = m_fifo.pop_front();
                    m_active   = 1'b1;
                    m_left     = int'(c[3:0]) + 1;
                    {m_j, m_k} = c[5:4];
                end else begin
                    m_j = 1'b0;
                    m_k = 1'b0;
                end
            end
            // Entry pushed on this edge is not visible to this edge's pop.
            if (cmd_valid && m_ready) m_fifo.push_back({cmd_op, cmd_rpt});
        end
        m_ready = (m_fifo.size() < DEPTH);
        m_ffrst = 1'b0;
        m_q     = nq;
    endtask

    task automatic check_all();
        chk("j_out",     j_out,     m_j);
        chk("k_out",     k_out,     m_k);
        chk("ff_rst",    ff_rst,    m_ffrst);
        chk("q_model",   q_model,   m_q);
        chk("busy",      busy,      m_active || (m_fifo.size() > 0));
        chk("mismatch",  mismatch,  m_mis);
        chk("done_cnt",  done_cnt,  m_done);
        chk("cmd_ready", cmd_ready, m_ready);
    endtask

    // One clock: present q_fb, take the edge, update model, compare 1 ns later.
    task automatic tick();
        q_fb = stuck_en ? stuck_val : (m_q ^ flip_q);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    logic [1:0]       t2_op  [3] = '{2'b10, 2'b01, 2'b11};
    logic [RPT_W-1:0] t2_rpt [3] = '{4'd0, 4'd0, 4'd2};
    logic [1:0]       t2_jk  [6] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00};
    logic             t2_q   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rpt = '0;
        abort = 1'b0; clr_err = 1'b0; q_fb = 1'b0;
        m_active = 1'b0; m_left = 0; m_j = 1'b0; m_k = 1'b0; m_ffrst = 1'b1;
        m_q = 1'b0; m_mis = 1'b0; m_done = '0; m_ready = 1'b1;

        // 1: reset held three cycles, then release
        repeat (3) tick();
        chk("rst_ff_rst", ff_rst, 1'b1);
        chk("rst_jk", {j_out, k_out}, 2'b00);
        chk("rst_q", q_model, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        rst = 1'b1;
        tick();
        chk("rel_ff_rst", ff_rst, 1'b0);

        // 2: SET/RESET/TOGGLE(rpt=2) back-to-back
        for (int i = 0; i < 7; i++) begin
            if (i < 3) begin
                cmd_valid = 1'b1; cmd_op = t2_op[i]; cmd_rpt = t2_rpt[i];
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk("seq_jk", {j_out, k_out}, t2_jk[i-1]);
                chk("seq_q",  q_model,        t2_q[i-1]);
            end
        end
        chk("seq_done", done_cnt, 8'd3);

        // 3: fill queue with long commands, hold valid through back-pressure
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rpt = 4'hF;
        repeat (5) tick();
        chk("full_ready", cmd_ready, 1'b0);
        repeat (15) tick();
        cmd_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        repeat (3) tick();

        // 4: abort during the 2nd of three queued commands
        rst = 1'b0; tick(); rst = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_op = t2_op[i]; cmd_rpt = 4'd3;
            tick();
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_jk", {j_out, k_out}, 2'b00);
        chk("ab_busy", busy, 1'b0);
        chk("ab_done", done_cnt, 8'd1);
        repeat (4) tick();
        chk("ab_quiet", {j_out, k_out}, 2'b00);

        // 5: feedback stuck at 0 after SET
        stuck_en = 1'b1; stuck_val = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rpt = 4'd0;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        chk("stuck_mis", mismatch, 1'b1);
        repeat (2) tick();
        chk("stuck_hold", mismatch, 1'b1);
        stuck_en = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_mis", mismatch, 1'b0);

        // 6: reset mid-TOGGLE, then resume
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rpt = 4'd7;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("mid_ff_rst", ff_rst, 1'b1);
        chk("mid_jk", {j_out, k_out}, 2'b00);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done_cnt, 8'd0);
        rst = 1'b1;
        tick();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rpt = 4'd1;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        chk("resume_done", done_cnt, 8'd1);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            rst       = ($urandom_range(99) != 0);
            cmd_valid = 1'($urandom_range(1));
            cmd_op    = 2'($urandom_range(3));
            cmd_rpt   = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(3));
            abort     = ($urandom_range(29) == 0);
            clr_err   = ($urandom_range(19) == 0);
            flip_q    = ($urandom_range(24) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
